output_accum: RTL and testbench
===============================

# output_accum

Output accumulation stage downstream of the tile controller and MAC array. It collects the four 4-lane partial-sum rows the array emits per tile pass and accumulates them across depth (N) passes in a 4×4 tile buffer. When the last depth pass of a tile is absorbed, it writes the finished tile to OutputMemory at the controller's tile address and returns the `Tile_Done` pulse that advances the controller's loop counters.

## Interface
- `PW`, 16: signed partial-sum width per lane from the MAC array.
- `AW`, 20: signed accumulator and OutputMemory word width per lane.

- `CLK` in 1: clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `Start` in 1: one-cycle job start; same pulse the controller sees.
- `MNT` in 12: job dimensions; M=`[11:8]`, N=`[7:4]`, T=`[3:0]`; sampled when `Start`=1.
- `ODST` in 4: tile address {m,t} from the controller.
- `PSUM_VALID` in 1: one row of partial sums is present this cycle.
- `PSUM_DATA` in 4*PW: row data; lane j is `[PW*j +: PW]`, signed.
- `OM_WE` out 1: OutputMemory write enable.
- `OM_ADDR` out 6: {tile address, row}.
- `OM_WDATA` out 4*AW: row write data; lane j is `[AW*j +: AW]`.
- `Tile_Done` out 1: one-cycle pulse per completed tile pass.
- `BUSY` out 1: a job is in progress.
- `ERR` out 1: sticky protocol error.

## Operation
- Derived pass counts: tn = (N>4)?2:1, tm = (M>4)?2:1, tt = (T>4)?2:1.
- Job length is tm*tt tiles. Each tile takes tn passes.
- States are IDLE, COLLECT and WRITE.
- **IDLE**
  - On `Start`: latch M, N, T; clear the pass index `nidx`, row counter `row`, tile counter and `ERR`.
  - Go to COLLECT. `BUSY` becomes 1.
- **COLLECT**, on each `PSUM_VALID`:
  - Lane j of `PSUM_DATA` is sign-extended to AW bits.
  - If `nidx`==0, write it into `buf[row][j]`. Otherwise set `buf[row][j]` += that value, with AW-bit two's-complement wrap and no saturation.
  - `ODST` is latched into the tile-address register when row 0 of pass 0 is accepted.
  - `row` increments from 0 to 3 and wraps to 0.
- **End of a pass** (row 3 accepted):
  - If `nidx` < tn-1: `nidx`++, stay in COLLECT, pulse `Tile_Done`.
  - Otherwise: `nidx`=0, go to WRITE.
- **WRITE**
  - Four consecutive cycles with `OM_WE`=1, `OM_ADDR`={latched tile address, r} and `OM_WDATA`=`buf[r]`, for r=0..3 in order.
  - After the r=3 write, pulse `Tile_Done` and increment the tile counter.
  - If the tile counter equals tm*tt: go to IDLE and deassert `BUSY`. Otherwise go to COLLECT.
- **Errors**
  - `PSUM_VALID` in IDLE or WRITE sets `ERR`, and the row is dropped.
  - `ERR` stays set until `RST` or the next `Start`.
- **Boundaries**
  - `Start` in any state aborts the current job. Any WRITE sequence is truncated: `OM_WE` is 0 from the next cycle. The block re-latches `MNT` and re-enters COLLECT with all counters 0.
  - `PSUM_VALID` and `Start` in the same cycle: `Start` wins and the row is dropped without setting `ERR`.
  - Gaps between rows are legal. `row` holds during gaps.
  - MNT with N=0 behaves as tn=1, and similarly for M and T.

## Timing
- Reset values: `OM_WE`=0, `OM_ADDR`=0, `OM_WDATA`=0, `Tile_Done`=0, `BUSY`=0, `ERR`=0. All internal counters and the state are 0/IDLE. The buffer contents are don't-care.
- All outputs are registered.
- Intermediate pass, row 3 accepted at edge k: `Tile_Done`=1 during cycle k+1 only.
- Final pass, row 3 accepted at edge k:
  - `OM_WE`=1 during cycles k+1..k+4, with rows 0..3.
  - `Tile_Done`=1 during cycle k+4, coincident with the row-3 write.
  - The block accepts `PSUM_VALID` again from cycle k+5.
- Last tile of the job: `BUSY`=0 from cycle k+5.
- `BUSY` rises in the cycle after the `Start` edge.
- `ERR` rises in the cycle after the offending edge.

## Test plan
- **Single pass.** MNT=0x444, then rows with lanes (1,2,3,4)×row#.
  - Expect one write burst to addresses 0..3 with matching data, `Tile_Done` once, and `BUSY` falling after the 4th write.
- **Depth accumulation.** MNT=0x484, pass 0 all lanes 100, pass 1 all lanes -30.
  - Expect `Tile_Done` after pass 0 with no write.
  - Then writes of 70 in every lane and a second `Tile_Done`.
- **Full job.** MNT=0x888 with `ODST` sequenced 0,1,4,5.
  - Expect 8 `Tile_Done` pulses and 4 write bursts at `OM_ADDR` bases 0x00, 0x04, 0x10, 0x14.
  - `BUSY` falls only after the last burst.
- **Sign and wrap.** Two passes of lane value 0x7FFF, with AW=20.
  - Expect 0x0FFFE.
  - Two passes of 0x8000 give 0xF0000.
- **Protocol error.** `PSUM_VALID` pulsed during the WRITE burst, and again in IDLE.
  - Expect `ERR`=1 sticky, burst data unchanged, and `ERR` cleared by the next `Start`.
- **Abort and reset.** `Start` at write cycle 2 truncates the burst: `OM_WE`=0 next cycle and the new job runs cleanly.
  - `RST` pulsed mid-COLLECT returns all outputs to 0 asynchronously.

Source files
------------

// File: rtl/output_accum.sv
// ---------------------------------------------------------------------------
// output_accum
// Accumulates the 4-lane partial-sum rows produced by the MAC array across
// depth passes in a 4x4 tile buffer. When the last depth pass of a tile has
// been absorbed, the finished tile is written to OutputMemory one row per
// cycle, and a Tile_Done pulse is returned to the tile controller.
//
// Ports
//   CLK, RST     clock (rising edge), asynchronous active-high reset
//   Start        one-cycle job start; also aborts any job in progress
//   MNT          job dimensions {M[11:8], N[7:4], T[3:0]}, sampled on Start
//   ODST         tile address {m,t} from the controller
//   PSUM_VALID   a row of partial sums is present on PSUM_DATA
//   PSUM_DATA    four signed PW-bit lanes, lane j at [PW*j +: PW]
//   OM_WE        OutputMemory write enable
//   OM_ADDR      {tile address, row}
//   OM_WDATA     four AW-bit lanes, lane j at [AW*j +: AW]
//   Tile_Done    one-cycle pulse per completed tile pass
//   BUSY         a job is in progress
//   ERR          sticky protocol error (row offered outside COLLECT)
// ---------------------------------------------------------------------------
module output_accum #(
    parameter int PW = 16,
    parameter int AW = 20
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            Start,
    input  logic [11:0]     MNT,
    input  logic [3:0]      ODST,
    input  logic            PSUM_VALID,
    input  logic [4*PW-1:0] PSUM_DATA,
    output logic            OM_WE,
    output logic [5:0]      OM_ADDR,
    output logic [4*AW-1:0] OM_WDATA,
    output logic            Tile_Done,
    output logic            BUSY,
    output logic            ERR
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_tn2;        // two depth passes per tile
    logic [2:0]  r_tiles;      // tm*tt: 1, 2 or 4
    logic [2:0]  r_tile_cnt;
    logic        r_nidx;       // depth pass index (tn is at most 2)
    logic [1:0]  r_row;
    logic [3:0]  r_taddr;
    logic [2:0]  r_wr;         // next row to emit; 4 = burst finished
    logic        r_last;       // the tile just written was the last of the job

    // Small 16-word tile buffer; accumulation needs a same-cycle
    // read-modify-write, so it is kept in flops rather than block RAM.
    logic [AW-1:0] r_buf [0:3][0:3];

    logic            w_accept;
    logic [1:0]      w_rd_idx;
    logic [AW-1:0]   w_ext [0:3];
    logic [AW-1:0]   w_sum [0:3];
    logic [4*AW-1:0] w_rd_row;

    assign w_accept = (r_state == S_COLLECT) && PSUM_VALID && !Start;
    // The first burst row is registered on the COLLECT->WRITE edge.
    assign w_rd_idx = (r_state == S_WRITE) ? r_wr[1:0] : 2'd0;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_ext[gi] = {{(AW-PW){PSUM_DATA[PW*gi+PW-1]}}, PSUM_DATA[PW*gi +: PW]};
            assign w_sum[gi] = r_buf[r_row][gi] + w_ext[gi];
            assign w_rd_row[AW*gi +: AW] = r_buf[w_rd_idx][gi];
        end
    endgenerate

    // Buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            for (int j = 0; j < 4; j++) begin
                r_buf[r_row][j] <= r_nidx ? w_sum[j] : w_ext[j];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_tn2      <= 1'b0;
            r_tiles    <= 3'd0;
            r_tile_cnt <= 3'd0;
            r_nidx     <= 1'b0;
            r_row      <= 2'd0;
            r_taddr    <= 4'd0;
            r_wr       <= 3'd0;
            r_last     <= 1'b0;
            OM_WE      <= 1'b0;
            OM_ADDR    <= 6'd0;
            OM_WDATA   <= '0;
            Tile_Done  <= 1'b0;
            BUSY       <= 1'b0;
            ERR        <= 1'b0;
        end else begin
            OM_WE     <= 1'b0;
            Tile_Done <= 1'b0;
            if (Start) begin
                // Start overrides everything, including a row in the same cycle.
                r_tn2      <= (MNT[7:4] > 4'd4);
                case ({MNT[11:8] > 4'd4, MNT[3:0] > 4'd4})
                    2'b11:   r_tiles <= 3'd4;
                    2'b10,
                    2'b01:   r_tiles <= 3'd2;
                    default: r_tiles <= 3'd1;
                endcase
                r_tile_cnt <= 3'd0;
                r_nidx     <= 1'b0;
                r_row      <= 2'd0;
                r_wr       <= 3'd0;
                r_last     <= 1'b0;
                ERR        <= 1'b0;
                BUSY       <= 1'b1;
                r_state    <= S_COLLECT;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (PSUM_VALID) ERR <= 1'b1;
                    end
                    S_COLLECT: begin
                        if (PSUM_VALID) begin
                            if (r_row == 2'd0 && !r_nidx) r_taddr <= ODST;
                            r_row <= r_row + 2'd1;
                            if (r_row == 2'd3) begin
                                if (r_tn2 && !r_nidx) begin
                                    r_nidx    <= 1'b1;
                                    Tile_Done <= 1'b1;
                                end else begin
                                    r_nidx   <= 1'b0;
                                    r_state  <= S_WRITE;
                                    OM_WE    <= 1'b1;
                                    OM_ADDR  <= {r_taddr, 2'd0};
                                    OM_WDATA <= w_rd_row;
                                    r_wr     <= 3'd1;
                                end
                            end
                        end
                    end
                    S_WRITE: begin
                        if (PSUM_VALID) ERR <= 1'b1;
                        if (r_wr < 3'd4) begin
                            OM_WE    <= 1'b1;
                            OM_ADDR  <= {r_taddr, r_wr[1:0]};
                            OM_WDATA <= w_rd_row;
                            r_wr     <= r_wr + 3'd1;
                            if (r_wr == 3'd3) begin
                                Tile_Done  <= 1'b1;
                                r_tile_cnt <= r_tile_cnt + 3'd1;
                                r_last     <= ((r_tile_cnt + 3'd1) == r_tiles);
                            end
                        end else begin
                            // One trailing cycle keeps the block in WRITE so
                            // that new rows are accepted only after it.
                            r_wr    <= 3'd0;
                            r_state <= r_last ? S_IDLE : S_COLLECT;
                            BUSY    <= !r_last;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_output_accum.sv
module tb_output_accum;

    localparam int PW = 16;
    localparam int AW = 20;

    logic            CLK = 1'b0;
    logic            RST;
    logic            Start;
    logic [11:0]     MNT;
    logic [3:0]      ODST;
    logic            PSUM_VALID;
    logic [4*PW-1:0] PSUM_DATA;
    logic            OM_WE;
    logic [5:0]      OM_ADDR;
    logic [4*AW-1:0] OM_WDATA;
    logic            Tile_Done;
    logic            BUSY;
    logic            ERR;

    output_accum #(.PW(PW), .AW(AW)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .MNT(MNT), .ODST(ODST),
        .PSUM_VALID(PSUM_VALID), .PSUM_DATA(PSUM_DATA),
        .OM_WE(OM_WE), .OM_ADDR(OM_ADDR), .OM_WDATA(OM_WDATA),
        .Tile_Done(Tile_Done), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Write/pulse capture, sampled mid-cycle.
    logic [5:0]      cap_addr [0:63];
    logic [4*AW-1:0] cap_data [0:63];
    int wr_n   = 0;
    int done_n = 0;

    always @(negedge CLK) begin
        if (OM_WE && wr_n < 64) begin
            cap_addr[wr_n] = OM_ADDR;
            cap_data[wr_n] = OM_WDATA;
            wr_n++;
        end
        if (Tile_Done) done_n++;
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    function automatic logic [4*AW-1:0] pk(input int a, input int b, input int c, input int d);
        return {d[AW-1:0], c[AW-1:0], b[AW-1:0], a[AW-1:0]};
    endfunction

    function automatic logic [4*PW-1:0] pd(input int a, input int b, input int c, input int d);
        return {d[PW-1:0], c[PW-1:0], b[PW-1:0], a[PW-1:0]};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_job(input logic [11:0] mnt);
        Start = 1'b1;
        MNT   = mnt;
        tick();
        Start = 1'b0;
    endtask

    task automatic send_row(input int a, input int b, input int c, input int d);
        PSUM_DATA  = pd(a, b, c, d);
        PSUM_VALID = 1'b1;
        tick();
        PSUM_VALID = 1'b0;
    endtask

    task automatic send_pass(input int v);
        for (int r = 0; r < 4; r++) send_row(v, v, v, v);
    endtask

    task automatic clear_caps();
        wr_n   = 0;
        done_n = 0;
    endtask

    int bases[4] = '{0, 1, 4, 5};

    initial begin
        RST = 1'b1; Start = 1'b0; MNT = '0; ODST = '0;
        PSUM_VALID = 1'b0; PSUM_DATA = '0;
        tick(); tick();
        RST = 1'b0;
        tick();
        check("rst_om_we", OM_WE, 0);
        check("rst_om_addr", OM_ADDR, 0);
        check("rst_om_wdata", OM_WDATA, 0);
        check("rst_tile_done", Tile_Done, 0);
        check("rst_busy", BUSY, 0);
        check("rst_err", ERR, 0);

        // ---- single pass, cycle-exact burst ----
        ODST = 4'd0;
        start_job(12'h444);
        check("t1_busy_rise", BUSY, 1);
        for (int r = 0; r < 4; r++) send_row(r+1, 2*(r+1), 3*(r+1), 4*(r+1));
        for (int r = 0; r < 4; r++) begin
            check($sformatf("t1_we_r%0d", r), OM_WE, 1);
            check($sformatf("t1_addr_r%0d", r), OM_ADDR, r);
            check($sformatf("t1_data_r%0d", r), OM_WDATA, pk(r+1, 2*(r+1), 3*(r+1), 4*(r+1)));
            check($sformatf("t1_done_r%0d", r), Tile_Done, (r == 3));
            check($sformatf("t1_busy_r%0d", r), BUSY, 1);
            tick();
        end
        check("t1_busy_fall", BUSY, 0);
        check("t1_we_end", OM_WE, 0);

        // ---- depth accumulation ----
        clear_caps();
        ODST = 4'd3;
        start_job(12'h484);
        send_pass(100);
        check("t2_mid_done", Tile_Done, 1);
        check("t2_mid_nowrite", OM_WE, 0);
        tick();
        check("t2_mid_done_low", Tile_Done, 0);
        send_pass(-30);
        repeat (4) tick();
        check("t2_done_cnt", done_n, 2);
        check("t2_wr_cnt", wr_n, 4);
        for (int r = 0; r < 4; r++) begin
            check($sformatf("t2_addr_r%0d", r), cap_addr[r], 12 + r);
            check($sformatf("t2_data_r%0d", r), cap_data[r], pk(70, 70, 70, 70));
        end
        check("t2_busy", BUSY, 0);

        // ---- full job 2x2 tiles, 2 passes each ----
        clear_caps();
        start_job(12'h888);
        for (int i = 0; i < 4; i++) begin
            ODST = bases[i][3:0];
            send_pass(i + 1);
            ODST = 4'hF;   // must not disturb the latched tile address
            for (int r = 0; r < 4; r++) send_row(r, r, r, r);
            repeat (4) tick();
            check($sformatf("t3_busy_tile%0d", i), BUSY, (i < 3));
        end
        check("t3_done_cnt", done_n, 8);
        check("t3_wr_cnt", wr_n, 16);
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < 4; r++) begin
                check($sformatf("t3_addr_%0d_%0d", i, r), cap_addr[4*i+r], bases[i]*4 + r);
                check($sformatf("t3_data_%0d_%0d", i, r), cap_data[4*i+r], pk(i+1+r, i+1+r, i+1+r, i+1+r));
            end
        end

        // ---- sign extension and wrap ----
        clear_caps();
        ODST = 4'd0;
        start_job(12'h484);
        send_pass(32'h7FFF);
        send_pass(32'h7FFF);
        repeat (4) tick();
        check("t4_pos_r0", cap_data[0], {4{20'h0FFFE}});
        check("t4_pos_r3", cap_data[3], {4{20'h0FFFE}});
        clear_caps();
        start_job(12'h484);
        send_pass(-32768);
        send_pass(-32768);
        repeat (4) tick();
        check("t4_neg_r0", cap_data[0], {4{20'hF0000}});
        check("t4_neg_r3", cap_data[3], {4{20'hF0000}});

        // ---- protocol errors ----
        clear_caps();
        ODST = 4'd2;
        start_job(12'h444);
        for (int r = 0; r < 4; r++) send_row(5, 6, 7, 8);
        check("t5_err_before", ERR, 0);
        PSUM_DATA  = pd(999, 999, 999, 999);
        PSUM_VALID = 1'b1;
        tick();
        PSUM_VALID = 1'b0;
        check("t5_err_write", ERR, 1);
        repeat (3) tick();
        check("t5_err_sticky", ERR, 1);
        check("t5_busy", BUSY, 0);
        check("t5_wr_cnt", wr_n, 4);
        for (int r = 0; r < 4; r++) begin
            check($sformatf("t5_addr_r%0d", r), cap_addr[r], 8 + r);
            check($sformatf("t5_data_r%0d", r), cap_data[r], pk(5, 6, 7, 8));
        end
        start_job(12'h444);
        check("t5_err_clear", ERR, 0);
        send_pass(1);
        repeat (4) tick();
        check("t5_err_clean_job", ERR, 0);
        PSUM_VALID = 1'b1;
        tick();
        PSUM_VALID = 1'b0;
        check("t5_err_idle", ERR, 1);
        tick();
        check("t5_err_idle_sticky", ERR, 1);

        // ---- Start with row in the same cycle, then abort mid-burst ----
        ODST = 4'd0;
        PSUM_DATA  = pd(500, 500, 500, 500);
        PSUM_VALID = 1'b1;
        Start = 1'b1;
        MNT   = 12'h444;
        tick();
        Start = 1'b0;
        PSUM_VALID = 1'b0;
        check("t6_start_row_err", ERR, 0);
        check("t6_busy", BUSY, 1);
        for (int r = 0; r < 4; r++) send_row(r+1, r+1, r+1, r+1);
        check("t6_we_c1", OM_WE, 1);
        tick();
        check("t6_we_c2", OM_WE, 1);
        check("t6_addr_c2", OM_ADDR, 1);
        Start = 1'b1;
        MNT   = 12'h444;
        tick();
        Start = 1'b0;
        check("t6_abort_we", OM_WE, 0);
        check("t6_abort_done", Tile_Done, 0);
        check("t6_abort_busy", BUSY, 1);
        clear_caps();
        ODST = 4'd1;
        for (int r = 0; r < 4; r++) send_row(r, -r, 2*r, 100);
        repeat (4) tick();
        check("t6_done_cnt", done_n, 1);
        check("t6_wr_cnt", wr_n, 4);
        for (int r = 0; r < 4; r++) begin
            check($sformatf("t6_addr_r%0d", r), cap_addr[r], 4 + r);
            check($sformatf("t6_data_r%0d", r), cap_data[r], pk(r, -r, 2*r, 100));
        end
        check("t6_busy_end", BUSY, 0);

        // ---- asynchronous reset mid-COLLECT ----
        start_job(12'h444);
        send_row(1, 1, 1, 1);
        send_row(2, 2, 2, 2);
        check("t7_busy_pre", BUSY, 1);
        RST = 1'b1;
        #2;
        check("t7_rst_busy", BUSY, 0);
        check("t7_rst_we", OM_WE, 0);
        check("t7_rst_addr", OM_ADDR, 0);
        check("t7_rst_wdata", OM_WDATA, 0);
        check("t7_rst_err", ERR, 0);
        check("t7_rst_done", Tile_Done, 0);
        RST = 1'b0;
        tick();
        clear_caps();
        ODST = 4'd6;
        start_job(12'h444);
        for (int r = 0; r < 4; r++) send_row(7*r, 1, -1, r);
        repeat (4) tick();
        check("t7_wr_cnt", wr_n, 4);
        for (int r = 0; r < 4; r++) begin
            check($sformatf("t7_addr_r%0d", r), cap_addr[r], 24 + r);
            check($sformatf("t7_data_r%0d", r), cap_data[r], pk(7*r, 1, -1, r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
